// File: rtl/aes_result_hex_pager.sv
// aes_result_hex_pager
// Captures one DATA_W-bit AES result through a valid/ready handshake. It then
// shows the result a page at a time on six seven-segment digits HEX0..HEX5.
// Each page is held for DWELL_CYCLES clock cycles. The display keeps looping
// over the pages until a new result is captured.
// The first full pass over the pages cannot be interrupted: in_ready stays low
// until the page counter has wrapped back to 0 once.
// Optional build macro PAGE_INDICATOR_EN:
//   - HEX5 shows the current page number (0-9).
//   - Data uses HEX0..HEX4 only, so each page carries five nibbles.
module aes_result_hex_pager #(
  parameter int DATA_W         = 128,
  parameter int DWELL_CYCLES   = 50000000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
`ifdef PAGE_INDICATOR_EN
  parameter int NPP            = 5,
`else
  parameter int NPP            = 6,
`endif
  parameter int NIBS           = DATA_W / 4,
  parameter int PAGES          = (NIBS + NPP - 1) / NPP,
  parameter int PW             = (PAGES > 1) ? $clog2(PAGES) : 1,
  parameter int TW             = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              hold,
  output logic              busy,
  output logic [PW-1:0]     page_idx,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX3,
  output logic [6:0]        HEX4,
  output logic [6:0]        HEX5
);

  localparam logic [TW-1:0] TMAX  = TW'(DWELL_CYCLES - 1);
  localparam logic [PW-1:0] PMAX  = PW'(PAGES - 1);
  localparam logic [6:0]    BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

  state_t              state_q, state_n;
  logic [TW-1:0]       timer_q, timer_n;
  logic [PW-1:0]       page_q, page_n;
  logic                shown_q, shown_n;
  logic [DATA_W-1:0]   data_p0, data_n;
  logic [6:0]          hex_n  [6];
  logic [6:0]          hex_p1 [6];
  logic                accept;

  // Seven-segment glyph for one hex nibble (active-low, bit order gfedcba).
  function automatic logic [6:0] glyph_lo(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // Converts an active-low pattern to the board polarity.
  function automatic logic [6:0] seg_pol(input logic [6:0] lo);
    return SEG_ACTIVE_LOW ? lo : ~lo;
  endfunction

  // Picks digit k of page pg out of the captured word.
  // Nibbles past the end of the word are shown blank.
  function automatic logic [6:0] data_digit(input logic [PW-1:0]     pg,
                                            input int                k,
                                            input logic [DATA_W-1:0] d);
    int         n;
    logic [3:0] nib;
    n = int'(pg) * NPP + k;
    if (n >= NIBS) return BLANK;
    nib = 4'(d >> (4 * n));
    return seg_pol(glyph_lo(nib));
  endfunction

`ifdef PAGE_INDICATOR_EN
  // Page-number digit for HEX5. Page numbers above 9 are shown blank.
  function automatic logic [6:0] page_digit(input logic [PW-1:0] pg);
    if (int'(pg) > 9) return BLANK;
    return seg_pol(glyph_lo(4'(pg)));
  endfunction
`endif

  assign accept   = in_valid && in_ready;
  assign in_ready = (state_q == IDLE) || shown_q;
  assign busy     = (state_q == SHOW);
  assign page_idx = page_q;

  // Next-state logic.
  // A handshake takes priority over a dwell expiry or a hold.
  always_comb begin
    state_n = state_q;
    timer_n = timer_q;
    page_n  = page_q;
    shown_n = shown_q;
    data_n  = data_p0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_n = SHOW;
          data_n  = in_data;
          timer_n = '0;
          page_n  = '0;
          shown_n = 1'b0;
        end
      end
      SHOW: begin
        if (accept) begin
          data_n  = in_data;
          timer_n = '0;
          page_n  = '0;
          shown_n = 1'b0;
        end else if (!hold) begin
          if (timer_q == TMAX) begin
            timer_n = '0;
            if (page_q == PMAX) begin
              page_n  = '0;
              shown_n = 1'b1;
            end else begin
              page_n = page_q + 1'b1;
            end
          end else begin
            timer_n = timer_q + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // ---- stage p0: control state and captured result ----
  // Control and data registers. The data register is also cleared by reset,
  // so a result captured before reset is discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      page_q  <= '0;
      shown_q <= 1'b0;
      data_p0 <= '0;
    end else begin
      state_q <= state_n;
      timer_q <= timer_n;
      page_q  <= page_n;
      shown_q <= shown_n;
      data_p0 <= data_n;
    end
  end

  // Digit decode for the current page.
  // All digits are blank while no result is held.
  always_comb begin
    for (int k = 0; k < 6; k++) hex_n[k] = BLANK;
    if (state_q == SHOW) begin
      for (int k = 0; k < NPP; k++) hex_n[k] = data_digit(page_q, k, data_p0);
`ifdef PAGE_INDICATOR_EN
      hex_n[5] = page_digit(page_q);
`endif
    end
  end

  // ---- stage p1: registered segment outputs ----
  // The digits follow page_idx and the data register one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 6; k++) hex_p1[k] <= BLANK;
    end else begin
      for (int k = 0; k < 6; k++) hex_p1[k] <= hex_n[k];
    end
  end

  assign HEX0 = hex_p1[0];
  assign HEX1 = hex_p1[1];
  assign HEX2 = hex_p1[2];
  assign HEX3 = hex_p1[3];
  assign HEX4 = hex_p1[4];
  assign HEX5 = hex_p1[5];

endmodule
